// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4-slot TDM demultiplexer.
package tdm_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        SYNC = 1'b1
    } state_t;

    localparam int SLOTS = 4;

    typedef logic [1:0] slot_t;

    localparam slot_t SLOT_A = 2'd0;
    localparam slot_t SLOT_B = 2'd1;
    localparam slot_t SLOT_C = 2'd2;
    localparam slot_t SLOT_D = 2'd3;

endpackage

// File: rtl/tdm_slot_counter.sv
// 2-bit slot counter: clear has priority over load-to-1, which has priority over increment.
module tdm_slot_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       load1_i,
    input  logic       en_i,
    output logic [1:0] cnt_o
);
    import tdm_pkg::*;

    slot_t cnt_q;

    // Slot index register; increment wraps naturally from slot d back to slot a.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= SLOT_A;
        end else if (clr_i) begin
            cnt_q <= SLOT_A;
        end else if (load1_i) begin
            cnt_q <= SLOT_B;
        end else if (en_i) begin
            cnt_q <= cnt_q + 2'd1;
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer: frame-sync hunt/lock FSM, slot holding registers
// and lane registers that update together once a whole frame has been seen.
module tdm_demux4 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic [WIDTH-1:0] out_d,
    output logic             out_valid,
    output logic [1:0]       cur_sel,
    output logic             locked,
    output logic             sync_err
);
    import tdm_pkg::*;

    state_t           state_q, state_d;
    slot_t            cnt_s, cap_slot_s;
    logic             cnt_clr_s, cnt_load1_s, cnt_en_s;
    logic             cap_s, err_s, done_s;
    logic [WIDTH-1:0] hold_a_q, hold_b_q, hold_c_q;
    logic [WIDTH-1:0] out_a_q, out_b_q, out_c_q, out_d_q;
    logic             out_valid_q, sync_err_q;

    tdm_slot_counter u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (cnt_clr_s),
        .load1_i (cnt_load1_s),
        .en_i    (cnt_en_s),
        .cnt_o   (cnt_s)
    );

    // A sync-marked sample is always slot a, whatever the counter says.
    assign cap_slot_s = frame_sync ? SLOT_A : cnt_s;

    // Next-state and per-sample action decode.
    always_comb begin
        state_d     = state_q;
        cnt_clr_s   = 1'b0;
        cnt_load1_s = 1'b0;
        cnt_en_s    = 1'b0;
        cap_s       = 1'b0;
        err_s       = 1'b0;
        done_s      = 1'b0;
        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        cap_s       = 1'b1;
                        cnt_load1_s = 1'b1;
                        state_d     = SYNC;
                    end else begin
                        cnt_clr_s   = 1'b1;
                    end
                end
                SYNC: begin
                    if (cnt_s == SLOT_A) begin
                        if (frame_sync) begin
                            cap_s    = 1'b1;
                            cnt_en_s = 1'b1;
                        end else begin
                            err_s     = 1'b1;
                            cnt_clr_s = 1'b1;
                            state_d   = HUNT;
                        end
                    end else if (frame_sync) begin
                        err_s       = 1'b1;
                        cap_s       = 1'b1;
                        cnt_load1_s = 1'b1;
                    end else begin
                        cap_s    = 1'b1;
                        cnt_en_s = 1'b1;
                        done_s   = (cnt_s == SLOT_D);
                    end
                end
                default: begin
                    state_d   = HUNT;
                    cnt_clr_s = 1'b1;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FSM state, slot holding registers and registered lane outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            hold_a_q    <= '0;
            hold_b_q    <= '0;
            hold_c_q    <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_c_q     <= '0;
            out_d_q     <= '0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= done_s;
            sync_err_q  <= err_s;
            if (cap_s) begin
                case (cap_slot_s)
                    SLOT_A:  hold_a_q <= in_data;
                    SLOT_B:  hold_b_q <= in_data;
                    SLOT_C:  hold_c_q <= in_data;
                    default: hold_a_q <= hold_a_q;
                endcase
            end
            // Slot d bypasses the holding bank so all lanes land in the same cycle.
            if (done_s) begin
                out_a_q <= hold_a_q;
                out_b_q <= hold_b_q;
                out_c_q <= hold_c_q;
                out_d_q <= in_data;
            end
        end
    end

    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_c     = out_c_q;
    assign out_d     = out_d_q;
    assign out_valid = out_valid_q;
    assign sync_err  = sync_err_q;
    assign cur_sel   = cnt_s;
    assign locked    = (state_q == SYNC);

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4 against a queue-based frame model.
module tb_tdm_demux4;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             frame_sync;
    logic [WIDTH-1:0] out_a, out_b, out_c, out_d;
    logic             out_valid;
    logic [1:0]       cur_sel;
    logic             locked;
    logic             sync_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: accepted samples of the current partial frame.
    logic [7:0] m_frame[$];
    logic [7:0] m_out[4];
    bit         m_locked;
    bit         m_valid;
    bit         m_err;

    tdm_demux4 #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .frame_sync (frame_sync),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_c      (out_c),
        .out_d      (out_d),
        .out_valid  (out_valid),
        .cur_sel    (cur_sel),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_frame.delete();
        for (int i = 0; i < 4; i++) m_out[i] = 8'h00;
        m_locked = 1'b0;
        m_valid  = 1'b0;
        m_err    = 1'b0;
    endfunction

    function automatic void model_step(input bit v, input bit s, input logic [7:0] d);
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (v) begin
            if (!m_locked) begin
                if (s) begin
                    m_frame  = {d};
                    m_locked = 1'b1;
                end
            end else if (s) begin
                if (m_frame.size() != 0) m_err = 1'b1;
                m_frame = {d};
            end else if (m_frame.size() == 0) begin
                m_err    = 1'b1;
                m_locked = 1'b0;
            end else begin
                m_frame.push_back(d);
                if (m_frame.size() == 4) begin
                    for (int i = 0; i < 4; i++) m_out[i] = m_frame[i];
                    m_valid = 1'b1;
                    m_frame.delete();
                end
            end
        end
    endfunction

    function automatic logic [31:0] exp_lanes();
        return {m_out[0], m_out[1], m_out[2], m_out[3]};
    endfunction

    // {out_valid, sync_err, locked, cur_sel}
    function automatic logic [4:0] exp_status();
        logic [1:0] sel;
        sel = 2'(m_frame.size());
        return {m_valid, m_err, m_locked, sel};
    endfunction

    task automatic drive(input bit v, input bit s, input logic [7:0] d);
        in_valid   = v;
        frame_sync = s;
        in_data    = d;
        @(posedge clk);
        #1;
        cyc++;
        model_step(v, s, d);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        in_valid   = 1'b0;
        frame_sync = 1'b0;
        in_data    = 8'h00;
        rst_n      = 1'b0;
        #2;
        model_reset();
        n_checks++;
        if ({out_a, out_b, out_c, out_d} !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_lanes: got %h expected %h", {out_a, out_b, out_c, out_d}, 32'h0);
        end
        n_checks++;
        if ({out_valid, sync_err, locked, cur_sel} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_status: got %b expected %b", {out_valid, sync_err, locked, cur_sel}, 5'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_frame();
        logic [7:0] d[4];
        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i == 0, d[i]);
            n_checks++;
            if ({out_valid, sync_err, locked, cur_sel} !== exp_status()) begin
                n_errors++;
                $display("FAIL basic_status[%0d]: got %b expected %b", i, {out_valid, sync_err, locked, cur_sel}, exp_status());
            end
        end
        n_checks++;
        if ({out_a, out_b, out_c, out_d} !== 32'h11223344 || out_valid !== 1'b1 || locked !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_frame: got lanes=%h valid=%b locked=%b expected 11223344 1 1", {out_a, out_b, out_c, out_d}, out_valid, locked);
        end
        drive(1'b0, 1'b0, 8'hFF);
        n_checks++;
        if (out_valid !== 1'b0 || {out_a, out_b, out_c, out_d} !== 32'h11223344) begin
            n_errors++;
            $display("FAIL basic_pulse_hold: got valid=%b lanes=%h expected 0 11223344", out_valid, {out_a, out_b, out_c, out_d});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d[8];
        int         pulses[$];
        int         errs;
        d = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04};
        errs = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, (i % 4) == 0, d[i]);
            if (out_valid === 1'b1) pulses.push_back(cyc);
            if (sync_err !== 1'b0) errs++;
            if (i == 3) begin
                n_checks++;
                if ({out_a, out_b, out_c, out_d} !== 32'hAABBCCDD) begin
                    n_errors++;
                    $display("FAIL b2b_frame1: got %h expected AABBCCDD", {out_a, out_b, out_c, out_d});
                end
            end
        end
        n_checks++;
        if (pulses.size() != 2 || errs != 0) begin
            n_errors++;
            $display("FAIL b2b_pulses: got pulses=%0d errs=%0d expected 2 0", pulses.size(), errs);
        end else begin
            n_checks++;
            if (pulses[1] - pulses[0] != 4) begin
                n_errors++;
                $display("FAIL b2b_spacing: got %0d expected 4", pulses[1] - pulses[0]);
            end
        end
        n_checks++;
        if ({out_a, out_b, out_c, out_d} !== 32'h01020304) begin
            n_errors++;
            $display("FAIL b2b_frame2: got %h expected 01020304", {out_a, out_b, out_c, out_d});
        end
    endtask

    task automatic test_hunt_ignore();
        logic [7:0] d[4];
        d = '{8'h12, 8'h34, 8'h56, 8'h78};
        do_reset();
        drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'h66);
        n_checks++;
        if (locked !== 1'b0 || cur_sel !== 2'd0 || sync_err !== 1'b0) begin
            n_errors++;
            $display("FAIL hunt_discard: got locked=%b sel=%0d err=%b expected 0 0 0", locked, cur_sel, sync_err);
        end
        for (int i = 0; i < 4; i++) drive(1'b1, i == 0, d[i]);
        n_checks++;
        if ({out_a, out_b, out_c, out_d} !== 32'h12345678 || out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL hunt_frame: got %h valid=%b expected 12345678 1", {out_a, out_b, out_c, out_d}, out_valid);
        end
    endtask

    task automatic test_resync();
        drive(1'b1, 1'b1, 8'hA1);
        drive(1'b1, 1'b0, 8'hB2);
        drive(1'b1, 1'b1, 8'h99);
        n_checks++;
        if (sync_err !== 1'b1 || cur_sel !== 2'd1 || out_valid !== 1'b0 || locked !== 1'b1) begin
            n_errors++;
            $display("FAIL resync_err: got err=%b sel=%0d valid=%b locked=%b expected 1 1 0 1", sync_err, cur_sel, out_valid, locked);
        end
        drive(1'b1, 1'b0, 8'hA0);
        n_checks++;
        if (sync_err !== 1'b0) begin
            n_errors++;
            $display("FAIL resync_pulse: got err=%b expected 0", sync_err);
        end
        drive(1'b1, 1'b0, 8'hB0);
        drive(1'b1, 1'b0, 8'hC0);
        n_checks++;
        if ({out_a, out_b, out_c, out_d} !== 32'h99A0B0C0 || out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL resync_frame: got %h valid=%b expected 99A0B0C0 1", {out_a, out_b, out_c, out_d}, out_valid);
        end
    endtask

    task automatic test_lost_sync();
        logic [31:0] prev;
        prev = {out_a, out_b, out_c, out_d};
        drive(1'b1, 1'b0, 8'h5A);
        n_checks++;
        if (sync_err !== 1'b1 || locked !== 1'b0 || out_valid !== 1'b0 || cur_sel !== 2'd0) begin
            n_errors++;
            $display("FAIL lost_sync: got err=%b locked=%b valid=%b sel=%0d expected 1 0 0 0", sync_err, locked, out_valid, cur_sel);
        end
        n_checks++;
        if ({out_a, out_b, out_c, out_d} !== prev) begin
            n_errors++;
            $display("FAIL lost_sync_hold: got %h expected %h", {out_a, out_b, out_c, out_d}, prev);
        end
    endtask

    task automatic test_reset_midframe();
        int bad;
        bad = 0;
        drive(1'b1, 1'b1, 8'hE1);
        drive(1'b1, 1'b0, 8'hE2);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({out_a, out_b, out_c, out_d} !== 32'h0 || {out_valid, sync_err, locked, cur_sel} !== 5'b0) begin
            n_errors++;
            $display("FAIL midreset_async: got lanes=%h status=%b expected 0 0", {out_a, out_b, out_c, out_d}, {out_valid, sync_err, locked, cur_sel});
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 8'hE3);
        if (out_valid !== 1'b0 || locked !== 1'b0) bad++;
        drive(1'b1, 1'b0, 8'hE4);
        if (out_valid !== 1'b0 || locked !== 1'b0) bad++;
        n_checks++;
        if (bad != 0 || {out_a, out_b, out_c, out_d} !== 32'h0) begin
            n_errors++;
            $display("FAIL midreset_nofr: got bad=%0d lanes=%h expected 0 0", bad, {out_a, out_b, out_c, out_d});
        end
    endtask

    task automatic test_gaps();
        logic [7:0] d[4];
        int         pulses;
        for (int f = 0; f < 6; f++) begin
            pulses = 0;
            for (int i = 0; i < 4; i++) d[i] = 8'($urandom_range(0, 255));
            for (int i = 0; i < 4; i++) begin
                for (int g = $urandom_range(0, 3); g > 0; g--) begin
                    drive(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
                    if (out_valid === 1'b1) pulses++;
                end
                drive(1'b1, i == 0, d[i]);
                if (out_valid === 1'b1) pulses++;
            end
            n_checks++;
            if ({out_a, out_b, out_c, out_d} !== {d[0], d[1], d[2], d[3]} || out_valid !== 1'b1 || pulses != 1) begin
                n_errors++;
                $display("FAIL gaps[%0d]: got %h valid=%b pulses=%0d expected %h 1 1", f, {out_a, out_b, out_c, out_d}, out_valid, pulses, {d[0], d[1], d[2], d[3]});
            end
        end
    endtask

    task automatic test_random();
        bit         v, s;
        logic [7:0] d;
        for (int n = 0; n < 600; n++) begin
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 4) == 0);
            d = 8'($urandom_range(0, 255));
            drive(v, s, d);
            n_checks++;
            if ({out_valid, sync_err, locked, cur_sel} !== exp_status()) begin
                n_errors++;
                $display("FAIL rand_status@%0d: got %b expected %b", cyc, {out_valid, sync_err, locked, cur_sel}, exp_status());
            end
            n_checks++;
            if ({out_a, out_b, out_c, out_d} !== exp_lanes()) begin
                n_errors++;
                $display("FAIL rand_lanes@%0d: got %h expected %h", cyc, {out_a, out_b, out_c, out_d}, exp_lanes());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_hunt_ignore();
        test_resync();
        test_lost_sync();
        test_reset_midframe();
        test_gaps();
        test_random();
        drive(1'b0, 1'b0, 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
